// File: rtl/axil_csr_slave.sv
// AXI4-Lite slave holding a bank of NUM_REGS 32-bit control/status registers.
// Optional build macro AXIL_CSR_DECERR_EN: out-of-range accesses answer DECERR instead of OKAY.
module axil_csr_slave #(
    parameter int NUM_REGS = 16
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,

    input  logic [10:0]              axi_awaddr,
    input  logic                     axi_awvalid,
    output logic                     axi_awready,

    input  logic [31:0]              axi_wdata,
    input  logic [3:0]               axi_wstrb,
    input  logic                     axi_wvalid,
    output logic                     axi_wready,

    output logic [1:0]               axi_bresp,
    output logic                     axi_bvalid,
    input  logic                     axi_bready,

    input  logic [10:0]              axi_araddr,
    input  logic                     axi_arvalid,
    output logic                     axi_arready,

    output logic [31:0]              axi_rdata,
    output logic [1:0]               axi_rresp,
    output logic                     axi_rvalid,
    input  logic                     axi_rready,

    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef AXIL_CSR_DECERR_EN
    localparam logic [1:0] RESP_OOR    = RESP_DECERR;
`else
    localparam logic [1:0] RESP_OOR    = RESP_OKAY;
`endif
    localparam logic [9:0] NUM_REGS_W  = 10'(NUM_REGS);

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
        end
        return merged;
    endfunction

    function automatic logic in_range(input logic [8:0] idx);
        return ({1'b0, idx} < NUM_REGS_W);
    endfunction

    logic        ready_en;
    logic        aw_held;
    logic [8:0]  aw_idx;
    logic        w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] regs [NUM_REGS];
    logic [31:0] rd_word;
    logic [8:0]  ar_idx;
    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic        commit;
    logic        unused_addr_bits;

    // Word addressing: the byte offset within a word carries no meaning here.
    assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0]};
    assign ar_idx           = axi_araddr[10:2];

    assign axi_awready = ready_en & ~aw_held;
    assign axi_wready  = ready_en & ~w_held;
    assign axi_arready = ready_en & ~axi_rvalid;

    assign aw_fire = axi_awvalid & axi_awready;
    assign w_fire  = axi_wvalid  & axi_wready;
    assign ar_fire = axi_arvalid & axi_arready;
    assign commit  = aw_held & w_held & ~axi_bvalid;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // AW and W are held independently; a captured pair waits for B to drain.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            aw_held <= 1'b0;
            aw_idx  <= '0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= axi_awaddr[10:2];
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= axi_wdata;
                w_strb <= axi_wstrb;
            end
        end
    end

    // An out-of-range index matches no entry, so it writes and pulses nothing.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && (aw_idx == 9'(i))) begin
                    regs[i] <= merge_bytes(regs[i], w_data, w_strb);
                end
                wr_pulse[i] <= commit && (aw_idx == 9'(i));
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            axi_bvalid <= 1'b0;
            axi_bresp  <= RESP_OKAY;
        end else if (commit) begin
            axi_bvalid <= 1'b1;
            axi_bresp  <= in_range(aw_idx) ? RESP_OKAY : RESP_OOR;
        end else if (axi_bready) begin
            axi_bvalid <= 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == 9'(i)) rd_word = regs[i];
        end
    end

    // Read captures pre-edge contents, so a same-edge commit is not visible.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= RESP_OKAY;
        end else if (ar_fire) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_word;
            axi_rresp  <= in_range(ar_idx) ? RESP_OKAY : RESP_OOR;
        end else if (axi_rready) begin
            axi_rvalid <= 1'b0;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: tb/tb_axil_csr_slave.sv
// Self-checking bench for axil_csr_slave: transaction-level model plus directed literal checks.
module tb_axil_csr_slave;

    localparam int NUM_REGS = 16;
`ifdef AXIL_CSR_DECERR_EN
    localparam logic [1:0] OOR = 2'b11;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [10:0] axi_awaddr = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b1;
    logic [10:0] axi_araddr = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready = 1'b1;
    logic [32*NUM_REGS-1:0] reg_q;
    logic [NUM_REGS-1:0]    wr_pulse;

    always #5 clk = ~clk;

    axil_csr_slave #(.NUM_REGS(NUM_REGS)) dut (
        .axi_aclk(clk), .axi_aresetn(rstn),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    // Transaction-level model: pending AW/W kept as queues, registers as a plain array.
    logic [31:0]       m_regs [NUM_REGS];
    int unsigned       aw_q [$];
    logic [35:0]       w_q [$];
    bit                m_ready_en;
    bit                m_bvalid;
    bit                m_rvalid;
    logic [1:0]        m_bresp;
    logic [1:0]        m_rresp;
    logic [31:0]       m_rdata;
    logic [NUM_REGS-1:0]    m_pulse;
    logic [32*NUM_REGS-1:0] m_q;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        aw_q.delete();
        w_q.delete();
        m_ready_en = 0; m_bvalid = 0; m_rvalid = 0;
        m_bresp = '0; m_rresp = '0; m_rdata = '0; m_pulse = '0; m_q = '0;
    endtask

    task automatic model_step();
        bit aw_fire, w_fire, ar_fire, commit;
        int idx;
        int unsigned a;
        logic [35:0] wd;
        aw_fire = axi_awvalid && m_ready_en && (aw_q.size() == 0);
        w_fire  = axi_wvalid  && m_ready_en && (w_q.size() == 0);
        ar_fire = axi_arvalid && m_ready_en && !m_rvalid;
        commit  = (aw_q.size() > 0) && (w_q.size() > 0) && !m_bvalid;
        if (ar_fire) begin
            idx = int'(axi_araddr) / 4;
            m_rdata  = (idx < NUM_REGS) ? m_regs[idx] : 32'h0;
            m_rresp  = (idx < NUM_REGS) ? 2'b00 : OOR;
            m_rvalid = 1;
        end else if (axi_rready) begin
            m_rvalid = 0;
        end
        m_pulse = '0;
        if (commit) begin
            a  = aw_q.pop_front();
            wd = w_q.pop_front();
            idx = int'(a) / 4;
            if (idx < NUM_REGS) begin
                for (int b = 0; b < 4; b++)
                    if (wd[32+b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
                m_pulse[idx] = 1'b1;
            end
            m_bresp  = (idx < NUM_REGS) ? 2'b00 : OOR;
            m_bvalid = 1;
        end else if (axi_bready) begin
            m_bvalid = 0;
        end
        if (aw_fire) aw_q.push_back(int'(axi_awaddr));
        if (w_fire)  w_q.push_back({axi_wstrb, axi_wdata});
        m_ready_en = 1;
        for (int i = 0; i < NUM_REGS; i++) m_q[32*i +: 32] = m_regs[i];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("awready", 512'(axi_awready), 512'(m_ready_en && (aw_q.size() == 0)));
            chk("wready",  512'(axi_wready),  512'(m_ready_en && (w_q.size() == 0)));
            chk("arready", 512'(axi_arready), 512'(m_ready_en && !m_rvalid));
            chk("bvalid",  512'(axi_bvalid),  512'(m_bvalid));
            if (m_bvalid) chk("bresp", 512'(axi_bresp), 512'(m_bresp));
            chk("rvalid",  512'(axi_rvalid),  512'(m_rvalid));
            if (m_rvalid) begin
                chk("rdata", 512'(axi_rdata), 512'(m_rdata));
                chk("rresp", 512'(axi_rresp), 512'(m_rresp));
            end
            chk("reg_q",    512'(reg_q),    512'(m_q));
            chk("wr_pulse", 512'(wr_pulse), 512'(m_pulse));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic axi_write(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
        bit aw_go, w_go;
        int k;
        axi_awaddr = addr; axi_awvalid = 1'b1;
        axi_wdata = data;  axi_wstrb = strb; axi_wvalid = 1'b1;
        axi_bready = 1'b1;
        k = 0;
        while ((axi_awvalid || axi_wvalid) && k < 50) begin
            aw_go = axi_awvalid && axi_awready;
            w_go  = axi_wvalid && axi_wready;
            @(negedge clk);
            if (aw_go) axi_awvalid = 1'b0;
            if (w_go)  axi_wvalid  = 1'b0;
            k++;
        end
        if (axi_awvalid || axi_wvalid) begin
            fail_now("write_addr_data_accept");
            axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        end
        k = 0;
        while (!axi_bvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!axi_bvalid) fail_now("write_bvalid");
        chk("wr_bresp", 512'(axi_bresp), 512'(exp_resp));
        chk("wr_pulse_high", 512'(wr_pulse), 512'(exp_pulse));
        @(negedge clk);
        chk("wr_pulse_low", 512'(wr_pulse), 512'(16'h0));
    endtask

    task automatic axi_read(input logic [10:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit go;
        int k;
        axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b1;
        k = 0;
        while (axi_arvalid && k < 50) begin
            go = axi_arready;
            @(negedge clk);
            if (go) axi_arvalid = 1'b0;
            k++;
        end
        if (axi_arvalid) begin
            fail_now("read_addr_accept");
            axi_arvalid = 1'b0;
        end
        k = 0;
        while (!axi_rvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!axi_rvalid) fail_now("read_rvalid");
        data = axi_rdata;
        resp = axi_rresp;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;

    initial begin
        // Reset and ready release
        repeat (3) @(negedge clk);
        chk("reset_awready", 512'(axi_awready), 512'(1'b0));
        chk("reset_arready", 512'(axi_arready), 512'(1'b0));
        rstn = 1'b1;
        #1 chk("release_awready_still_low", 512'(axi_awready), 512'(1'b0));
        @(negedge clk);
        chk("ready_after_first_edge", 512'(axi_awready), 512'(1'b1));

        // Full-word write and read back
        axi_write(11'h008, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004);
        chk("reg2_value", 512'(reg_q[95:64]), 512'(32'hDEADBEEF));
        axi_read(11'h008, rd, rr);
        chk("read_reg2", 512'(rd), 512'(32'hDEADBEEF));
        chk("read_reg2_resp", 512'(rr), 512'(2'b00));

        // Byte strobes: lanes 0 and 2 replaced
        axi_write(11'h004, 32'h11223344, 4'hF, 2'b00, 16'h0002);
        axi_write(11'h004, 32'hAABBCCDD, 4'b0101, 2'b00, 16'h0002);
        chk("reg1_strobe_merge", 512'(reg_q[63:32]), 512'(32'h11BB33DD));
        axi_read(11'h007, rd, rr);
        chk("read_low_bits_ignored", 512'(rd), 512'(32'h11BB33DD));

        // W well ahead of AW, B stalled, second pair deferred
        axi_bready = 1'b0;
        axi_wdata = 32'h55667788; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        chk("w_first_wready", 512'(axi_wready), 512'(1'b1));
        @(negedge clk);
        axi_wvalid = 1'b0;
        chk("wready_after_capture", 512'(axi_wready), 512'(1'b0));
        repeat (4) @(negedge clk);
        axi_awaddr = 11'h00C; axi_awvalid = 1'b1;
        chk("late_aw_awready", 512'(axi_awready), 512'(1'b1));
        @(negedge clk);
        axi_awvalid = 1'b0;
        chk("bvalid_before_commit", 512'(axi_bvalid), 512'(1'b0));
        @(negedge clk);
        chk("bvalid_after_commit", 512'(axi_bvalid), 512'(1'b1));
        chk("pulse_reg3", 512'(wr_pulse), 512'(16'h0008));
        chk("reg3_value", 512'(reg_q[127:96]), 512'(32'h55667788));
        axi_awaddr = 11'h010; axi_awvalid = 1'b1;
        axi_wdata = 32'h01020304; axi_wvalid = 1'b1;
        chk("second_awready", 512'(axi_awready), 512'(1'b1));
        chk("second_wready", 512'(axi_wready), 512'(1'b1));
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        chk("bvalid_hold_2", 512'(axi_bvalid), 512'(1'b1));
        chk("awready_while_held", 512'(axi_awready), 512'(1'b0));
        @(negedge clk);
        chk("bvalid_hold_3", 512'(axi_bvalid), 512'(1'b1));
        chk("reg4_deferred", 512'(reg_q[159:128]), 512'(32'h0));
        @(negedge clk);
        chk("bvalid_hold_4", 512'(axi_bvalid), 512'(1'b1));
        axi_bready = 1'b1;
        @(negedge clk);
        chk("bvalid_drained", 512'(axi_bvalid), 512'(1'b0));
        @(negedge clk);
        chk("deferred_commit_bvalid", 512'(axi_bvalid), 512'(1'b1));
        chk("pulse_reg4", 512'(wr_pulse), 512'(16'h0010));
        chk("reg4_value", 512'(reg_q[159:128]), 512'(32'h01020304));
        @(negedge clk);

        // Read with rready stalled for three cycles
        axi_rready = 1'b0;
        axi_araddr = 11'h00C; axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_rvalid", 512'(axi_rvalid), 512'(1'b1));
            chk("stall_arready", 512'(axi_arready), 512'(1'b0));
            chk("stall_rdata", 512'(axi_rdata), 512'(32'h55667788));
            if (k == 2) axi_rready = 1'b1;
            @(negedge clk);
        end
        chk("rvalid_after_rready", 512'(axi_rvalid), 512'(1'b0));

        // Out-of-range, top register boundary, empty strobe
        axi_write(11'h040, 32'hFFFFFFFF, 4'hF, OOR, 16'h0000);
        chk("oor_no_alias_reg0", 512'(reg_q[31:0]), 512'(32'h0));
        axi_read(11'h7FC, rd, rr);
        chk("oor_rdata", 512'(rd), 512'(32'h0));
        chk("oor_rresp", 512'(rr), 512'(OOR));
        axi_write(11'h03C, 32'hCAFEF00D, 4'hF, 2'b00, 16'h8000);
        axi_read(11'h03C, rd, rr);
        chk("read_reg15", 512'(rd), 512'(32'hCAFEF00D));
        chk("read_reg15_resp", 512'(rr), 512'(2'b00));
        axi_write(11'h008, 32'h12345678, 4'h0, 2'b00, 16'h0004);
        chk("strobe_zero_unchanged", 512'(reg_q[95:64]), 512'(32'hDEADBEEF));

        // Read and commit to the same register on the same edge
        axi_awaddr = 11'h004; axi_wdata = 32'h99999999; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_araddr = 11'h004; axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        chk("same_edge_rvalid", 512'(axi_rvalid), 512'(1'b1));
        chk("same_edge_old_data", 512'(axi_rdata), 512'(32'h11BB33DD));
        chk("same_edge_bvalid", 512'(axi_bvalid), 512'(1'b1));
        chk("same_edge_new_reg", 512'(reg_q[63:32]), 512'(32'h99999999));
        @(negedge clk);

        // Asynchronous reset while an AW is held
        axi_awaddr = 11'h000; axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        chk("aw_held_before_reset", 512'(axi_awready), 512'(1'b0));
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_reg_q", 512'(reg_q), 512'(0));
        chk("async_awready", 512'(axi_awready), 512'(1'b0));
        chk("async_wready", 512'(axi_wready), 512'(1'b0));
        chk("async_arready", 512'(axi_arready), 512'(1'b0));
        chk("async_bvalid", 512'(axi_bvalid), 512'(1'b0));
        chk("async_rvalid", 512'(axi_rvalid), 512'(1'b0));
        chk("async_rdata", 512'(axi_rdata), 512'(32'h0));
        chk("async_pulse", 512'(wr_pulse), 512'(16'h0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1 chk("rerelease_awready_low", 512'(axi_awready), 512'(1'b0));
        @(negedge clk);
        chk("rerelease_awready", 512'(axi_awready), 512'(1'b1));
        chk("rerelease_wready", 512'(axi_wready), 512'(1'b1));
        axi_wdata = 32'h77777777; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        @(negedge clk);
        axi_wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("aborted_aw_no_commit", 512'(axi_bvalid), 512'(1'b0));
        end
        axi_awaddr = 11'h000; axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        @(negedge clk);
        chk("post_reset_commit", 512'(axi_bvalid), 512'(1'b1));
        chk("post_reset_pulse", 512'(wr_pulse), 512'(16'h0001));
        chk("post_reset_reg0", 512'(reg_q[31:0]), 512'(32'h77777777));
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
